io_bus_ctrl: RTL and testbench

- Downstream consumer of the CPU IO address/data registers (io_addr 8-bit, io_data 16-bit).
- Turns single-cycle CPU IO read/write requests into a stalled, acked handshake on the peripheral IO bus.
- Stalls the CPU until the device responds.
- Returns read data to the CPU.

---
 rtl/io_bus_ctrl_pkg.sv | 26 ++
 rtl/io_timeout_ctr.sv | 28 ++
 rtl/io_bus_ctrl.sv | 124 ++++++++++++
 tb/tb_io_bus_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_ctrl_pkg.sv
// Shared definitions for the peripheral IO bus controller: bus widths, state
// encodings and the value returned when a read is abandoned.
package io_bus_ctrl_pkg;

    localparam int IO_ADDR_W = 8;
    localparam int IO_DATA_W = 16;

    localparam logic [1:0] IO_ST_IDLE = 2'd0;
    localparam logic [1:0] IO_ST_WR   = 2'd1;
    localparam logic [1:0] IO_ST_RD   = 2'd2;
    localparam logic [1:0] IO_ST_DONE = 2'd3;

    localparam logic [IO_DATA_W-1:0] IO_BUS_FLOAT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = IO_ST_IDLE,
        ST_WR   = IO_ST_WR,
        ST_RD   = IO_ST_RD,
        ST_DONE = IO_ST_DONE
    } io_state_t;

    function automatic logic is_strobe_state(input io_state_t s);
        return (s == ST_WR) || (s == ST_RD);
    endfunction

endpackage

// File: rtl/io_timeout_ctr.sv
// Cycle counter that flags when a bus transaction has waited too long for an ack.
// Only built when IO_TIMEOUT_EN is defined.
`ifdef IO_TIMEOUT_EN
module io_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == TO_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/io_bus_ctrl.sv
// Converts single-cycle CPU IO requests into a stalled strobe/ack handshake on
// the peripheral bus. Define IO_TIMEOUT_EN to abort transactions the device never acks.
module io_bus_ctrl
    import io_bus_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IO_ADDR_W-1:0] io_addr,
    input  logic [IO_DATA_W-1:0] io_data,
    input  logic                 io_wr_req,
    input  logic                 io_rd_req,
    output logic                 cpu_stall,
    output logic [IO_DATA_W-1:0] io_rd_data,
    output logic                 io_rd_valid,
    output logic                 io_err,
    input  logic                 err_clr,
    output logic [IO_ADDR_W-1:0] dev_addr,
    output logic [IO_DATA_W-1:0] dev_wdata,
    output logic                 dev_we,
    output logic                 dev_re,
    input  logic [IO_DATA_W-1:0] dev_rdata,
    input  logic                 dev_ack
);

    io_state_t state;
    logic      to_terminal;
    logic      timeout_abort;

`ifdef IO_TIMEOUT_EN
    io_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!is_strobe_state(state)),
        .enable  (is_strobe_state(state) && !dev_ack),
        .terminal(to_terminal)
    );

    // A late ack on the terminal cycle still counts as a real completion.
    assign timeout_abort = is_strobe_state(state) && !dev_ack && to_terminal;

    always_ff @(posedge clk) begin
        if (rst) begin
            io_err <= 1'b0;
        end else if (timeout_abort) begin
            io_err <= 1'b1;
        end else if (err_clr) begin
            io_err <= 1'b0;
        end
    end
`else
    localparam int unused_to_cfg = TIMEOUT_CYCLES + TO_W;
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign to_terminal    = 1'b0;
    assign timeout_abort  = 1'b0;
    assign io_err         = 1'b0;
`endif

    assign cpu_stall = (state != ST_IDLE);

    // Handshake FSM; every bus-side output is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            dev_addr    <= '0;
            dev_wdata   <= '0;
            dev_we      <= 1'b0;
            dev_re      <= 1'b0;
            io_rd_data  <= '0;
            io_rd_valid <= 1'b0;
        end else begin
            io_rd_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (io_wr_req) begin
                        dev_addr  <= io_addr;
                        dev_wdata <= io_data;
                        dev_we    <= 1'b1;
                        state     <= ST_WR;
                    end else if (io_rd_req) begin
                        dev_addr <= io_addr;
                        dev_re   <= 1'b1;
                        state    <= ST_RD;
                    end
                end
                ST_WR: begin
                    if (dev_ack || timeout_abort) begin
                        dev_we <= 1'b0;
                        state  <= ST_DONE;
                    end
                end
                ST_RD: begin
                    if (dev_ack) begin
                        io_rd_data  <= dev_rdata;
                        io_rd_valid <= 1'b1;
                        dev_re      <= 1'b0;
                        state       <= ST_DONE;
                    end else if (timeout_abort) begin
                        io_rd_data  <= IO_BUS_FLOAT;
                        io_rd_valid <= 1'b1;
                        dev_re      <= 1'b0;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    dev_we <= 1'b0;
                    dev_re <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed bench for io_bus_ctrl: a table of whole transactions plus hand-written
// reset, idle-ack and (with IO_TIMEOUT_EN) timeout sequences.
module tb_io_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  io_addr;
    logic [15:0] io_data;
    logic        io_wr_req;
    logic        io_rd_req;
    logic        cpu_stall;
    logic [15:0] io_rd_data;
    logic        io_rd_valid;
    logic        io_err;
    logic        err_clr;
    logic [7:0]  dev_addr;
    logic [15:0] dev_wdata;
    logic        dev_we;
    logic        dev_re;
    logic [15:0] dev_rdata;
    logic        dev_ack;

    int errors = 0;
    int checks = 0;

    io_bus_ctrl #(
        .TIMEOUT_CYCLES(8),
        .TO_W          (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .io_addr    (io_addr),
        .io_data    (io_data),
        .io_wr_req  (io_wr_req),
        .io_rd_req  (io_rd_req),
        .cpu_stall  (cpu_stall),
        .io_rd_data (io_rd_data),
        .io_rd_valid(io_rd_valid),
        .io_err     (io_err),
        .err_clr    (err_clr),
        .dev_addr   (dev_addr),
        .dev_wdata  (dev_wdata),
        .dev_we     (dev_we),
        .dev_re     (dev_re),
        .dev_rdata  (dev_rdata),
        .dev_ack    (dev_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [7:0]  addr;
        logic [15:0] data;
        int          ack_at;
        logic [15:0] rdata;
        logic        mid_req;
        int          exp_we;
        int          exp_re;
        int          exp_stall;
        int          exp_valid;
        logic [7:0]  exp_addr;
        logic [15:0] exp_wdata;
        logic [15:0] exp_rd_data;
    } vec_t;

    int          obs_we, obs_re, obs_stall, obs_valid, obs_both;
    logic [7:0]  obs_first_addr, obs_last_addr;
    logic [15:0] obs_first_wdata, obs_last_wdata;
    logic        obs_done;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drives one request and follows it until the controller returns to idle.
    task automatic apply_stimulus(input vec_t v);
        int strobes;
        logic seen;
        strobes = 0;
        seen = 1'b0;
        obs_we = 0; obs_re = 0; obs_stall = 0; obs_valid = 0; obs_both = 0;
        obs_done = 1'b0;
        obs_first_addr = '0; obs_last_addr = '0;
        obs_first_wdata = '0; obs_last_wdata = '0;
        @(negedge clk);
        io_wr_req = v.wr;
        io_rd_req = v.rd;
        io_addr   = v.addr;
        io_data   = v.data;
        for (int cyc = 0; cyc < 40 && !obs_done; cyc++) begin
            @(negedge clk);
            io_wr_req = 1'b0;
            io_rd_req = 1'b0;
            dev_ack   = 1'b0;
            if (cpu_stall) begin
                seen = 1'b1;
                obs_stall++;
            end else if (seen) begin
                obs_done = 1'b1;
            end
            if (dev_we) obs_we++;
            if (dev_re) obs_re++;
            if (dev_we && dev_re) obs_both++;
            if (io_rd_valid) obs_valid++;
            if (dev_we || dev_re) begin
                strobes++;
                if (strobes == 1) begin
                    obs_first_addr  = dev_addr;
                    obs_first_wdata = dev_wdata;
                    if (v.mid_req) io_rd_req = 1'b1;
                end
                obs_last_addr  = dev_addr;
                obs_last_wdata = dev_wdata;
                if (strobes == v.ack_at) begin
                    dev_ack   = 1'b1;
                    dev_rdata = v.rdata;
                end
            end
        end
        check_output("txn_completes", 32'(obs_done), 32'd1);
    endtask

    task automatic check_vector(input int idx, input vec_t v);
        string p;
        p = $sformatf("v%0d_", idx);
        check_output({p, "we_cycles"},   32'(obs_we),    32'(v.exp_we));
        check_output({p, "re_cycles"},   32'(obs_re),    32'(v.exp_re));
        check_output({p, "stall_cycles"},32'(obs_stall), 32'(v.exp_stall));
        check_output({p, "valid_pulses"},32'(obs_valid), 32'(v.exp_valid));
        check_output({p, "we_re_overlap"},32'(obs_both), 32'd0);
        check_output({p, "addr_first"},  32'(obs_first_addr),  32'(v.exp_addr));
        check_output({p, "addr_last"},   32'(obs_last_addr),   32'(v.exp_addr));
        check_output({p, "wdata_first"}, 32'(obs_first_wdata), 32'(v.exp_wdata));
        check_output({p, "wdata_last"},  32'(obs_last_wdata),  32'(v.exp_wdata));
        check_output({p, "rd_data"},     32'(io_rd_data),      32'(v.exp_rd_data));
        check_output({p, "err"},         32'(io_err),          32'd0);
    endtask

    vec_t vecs[5];
    int   busy;

    initial begin
        //            wr    rd    addr   data      ack rdata     mid   we re st vl addr   wdata     rd_data
        vecs[0] = '{1'b1, 1'b0, 8'h12, 16'hBEEF, 1, 16'h0000, 1'b0, 1, 0, 2, 0, 8'h12, 16'hBEEF, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 8'h40, 16'h7777, 5, 16'h1234, 1'b0, 0, 5, 6, 1, 8'h40, 16'hBEEF, 16'h1234};
        vecs[2] = '{1'b1, 1'b1, 8'h55, 16'hA5A5, 2, 16'hDEAD, 1'b0, 2, 0, 3, 0, 8'h55, 16'hA5A5, 16'h1234};
        vecs[3] = '{1'b0, 1'b1, 8'h7F, 16'h0000, 1, 16'h8001, 1'b0, 0, 1, 2, 1, 8'h7F, 16'hA5A5, 16'h8001};
        vecs[4] = '{1'b1, 1'b0, 8'hFF, 16'h0001, 3, 16'h4321, 1'b1, 3, 0, 4, 0, 8'hFF, 16'h0001, 16'h8001};

        rst = 1'b1; io_addr = '0; io_data = '0; io_wr_req = 1'b0; io_rd_req = 1'b0;
        err_clr = 1'b0; dev_rdata = '0; dev_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_stall", 32'(cpu_stall), 32'd0);
        check_output("reset_strobes", 32'({dev_we, dev_re, io_rd_valid, io_err}), 32'd0);
        check_output("reset_addr_data", {8'(dev_addr), 16'(dev_wdata)}, 32'd0);
        check_output("reset_rd_data", 32'(io_rd_data), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i]);
            check_vector(i, vecs[i]);
        end

        // Acks while idle must not start anything.
        busy = 0;
        @(negedge clk);
        dev_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cpu_stall || dev_we || dev_re || io_rd_valid) busy++;
        end
        dev_ack = 1'b0;
        check_output("idle_ack_ignored", 32'(busy), 32'd0);

        // Reset on the 3rd read strobe cycle with a simultaneous ack.
        @(negedge clk);
        io_addr = 8'h22;
        io_rd_req = 1'b1;
        @(negedge clk);
        io_rd_req = 1'b0;
        check_output("rst_seq_re_c1", 32'(dev_re), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check_output("rst_seq_re_c3", 32'(dev_re), 32'd1);
        rst = 1'b1;
        dev_ack = 1'b1;
        dev_rdata = 16'hCAFE;
        @(negedge clk);
        rst = 1'b0;
        dev_ack = 1'b0;
        check_output("rst_seq_outputs", 32'({cpu_stall, dev_we, dev_re, io_rd_valid, io_err}), 32'd0);
        check_output("rst_seq_rd_data", 32'(io_rd_data), 32'd0);
        check_output("rst_seq_addr", 32'(dev_addr), 32'd0);
        @(negedge clk);
        check_output("rst_seq_no_valid", 32'({cpu_stall, io_rd_valid}), 32'd0);

`ifdef IO_TIMEOUT_EN
        begin
            vec_t tv;
            // Unmapped read: never acked, aborted after 8 strobe cycles.
            tv = '{1'b0, 1'b1, 8'h99, 16'h0000, 0, 16'h0000, 1'b0, 0, 8, 9, 1, 8'h99, 16'h0000, 16'hFFFF};
            apply_stimulus(tv);
            check_output("to_re_cycles", 32'(obs_re), 32'd8);
            check_output("to_stall", 32'(obs_stall), 32'd9);
            check_output("to_valid", 32'(obs_valid), 32'd1);
            check_output("to_rd_data", 32'(io_rd_data), 32'hFFFF);
            check_output("to_err_set", 32'(io_err), 32'd1);
            repeat (3) @(negedge clk);
            check_output("to_err_sticky", 32'(io_err), 32'd1);
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            check_output("to_err_cleared", 32'(io_err), 32'd0);

            // Ack arriving on the terminal-count cycle completes normally.
            tv = '{1'b0, 1'b1, 8'h9A, 16'h0000, 8, 16'h5A5A, 1'b0, 0, 8, 9, 1, 8'h9A, 16'h0000, 16'h5A5A};
            apply_stimulus(tv);
            check_vector(9, tv);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
